max_pooling_fprop1_win_addr_gen: RTL and testbench

Window address generator for the max-pooling forward pass. It walks every K×K pooling window of an in_h × in_w feature map at stride S and emits one linear input address per cycle: row·in_w + col. The row·in_w product comes from the team's combinational 17s×17s→17 multiplier instance, which sits in the parent. This block drives that multiplier's operands and consumes its product, then feeds the downstream window-max comparator over a valid/ready stream.

---
 rtl/max_pooling_fprop1_pkg.sv | 9 +
 rtl/max_pooling_fprop1_win_addr_gen_if.sv | 14 +
 rtl/max_pooling_fprop1_win_cnt.sv | 72 +++++++
 rtl/max_pooling_fprop1_win_addr_gen.sv | 106 ++++++++++
 tb/tb_max_pooling_fprop1_win_addr_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/max_pooling_fprop1_pkg.sv
// max_pooling_fprop1_pkg: shared types and widths for the max-pooling window address generator.
//   state_t    - controller states
//   DATA_WIDTH - address / multiplier operand width
//   DIM_W      - feature-map dimension width
package max_pooling_fprop1_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int DATA_WIDTH = 17;
    localparam int DIM_W = 16;
endpackage

// File: rtl/max_pooling_fprop1_win_addr_gen_if.sv
// max_pooling_fprop1_win_addr_gen_if: address stream from the generator to the window-max comparator.
//   addr_out/addr_valid/addr_ready - valid/ready address beat
//   win_last/tile_last             - last address of a window / of the job
interface max_pooling_fprop1_win_addr_gen_if #(
    parameter int DATA_WIDTH = max_pooling_fprop1_pkg::DATA_WIDTH
) ();
    logic [DATA_WIDTH-1:0] addr_out;
    logic                  addr_valid;
    logic                  addr_ready;
    logic                  win_last;
    logic                  tile_last;
    modport master (output addr_out, addr_valid, win_last, tile_last, input addr_ready);
    modport slave  (input addr_out, addr_valid, win_last, tile_last, output addr_ready);
endinterface

// File: rtl/max_pooling_fprop1_win_cnt.sv
// max_pooling_fprop1_win_cnt: nested oy_base/ox_base/ky/kx window walker.
//   ap_clk, ap_rst_n - clock, async active-low reset
//   clear            - zero all counters (job start)
//   advance          - step to the next window position
//   dim_h, dim_w     - latched feature-map dimensions
//   row, col         - current input coordinate
//   win_last         - current position is kx=ky=K-1
//   tile_last        - current position is the last of the job
module max_pooling_fprop1_win_cnt
    import max_pooling_fprop1_pkg::*;
#(
    parameter int POOL_K = 2,
    parameter int STRIDE = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] dim_h,
    input  logic [DIM_W-1:0] dim_w,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             win_last,
    output logic             tile_last
);
    localparam int KW = 4;
    localparam logic [DIM_W+1:0] SK = (DIM_W+2)'(STRIDE + POOL_K);
    logic [DIM_W-1:0] oy_q, oy_d, ox_q, ox_d;
    logic [KW-1:0]    ky_q, ky_d, kx_q, kx_d;
    logic             kx_wrap, ky_wrap, ox_wrap, oy_wrap;
    // The next window in a dimension exists only if base+S+K still fits.
    assign kx_wrap   = kx_q == KW'(POOL_K - 1);
    assign ky_wrap   = ky_q == KW'(POOL_K - 1);
    assign ox_wrap   = {2'b0, ox_q} + SK > {2'b0, dim_w};
    assign oy_wrap   = {2'b0, oy_q} + SK > {2'b0, dim_h};
    assign win_last  = kx_wrap & ky_wrap;
    assign tile_last = win_last & ox_wrap & oy_wrap;
    assign row       = oy_q + DIM_W'(ky_q);
    assign col       = ox_q + DIM_W'(kx_q);

    always_comb begin
        oy_d = oy_q;
        ox_d = ox_q;
        ky_d = ky_q;
        kx_d = kx_q;
        if (clear) begin
            oy_d = '0;
            ox_d = '0;
            ky_d = '0;
            kx_d = '0;
        end else if (advance) begin
            kx_d = kx_wrap ? '0 : kx_q + KW'(1);
            if (kx_wrap) ky_d = ky_wrap ? '0 : ky_q + KW'(1);
            if (win_last) ox_d = ox_wrap ? '0 : ox_q + DIM_W'(STRIDE);
            if (win_last & ox_wrap) oy_d = oy_q + DIM_W'(STRIDE);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            oy_q <= '0;
            ox_q <= '0;
            ky_q <= '0;
            kx_q <= '0;
        end else begin
            oy_q <= oy_d;
            ox_q <= ox_d;
            ky_q <= ky_d;
            kx_q <= kx_d;
        end
    end
endmodule

// File: rtl/max_pooling_fprop1_win_addr_gen.sv
// max_pooling_fprop1_win_addr_gen: emits row*in_w+col for every KxK pooling window at stride S.
//   ap_clk, ap_rst_n              - clock, async active-low reset
//   ap_start/ap_done/ap_idle/ap_ready - block-level control handshake
//   in_h, in_w                    - feature-map dimensions, sampled on start accept
//   mul_din0/mul_din1/mul_dout    - operands to / product from the external multiplier
//   m_axis                        - address stream (addr, valid/ready, win_last, tile_last)
module max_pooling_fprop1_win_addr_gen
    import max_pooling_fprop1_pkg::*;
#(
    parameter int DATA_WIDTH = max_pooling_fprop1_pkg::DATA_WIDTH,
    parameter int POOL_K = 2,
    parameter int STRIDE = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [DIM_W-1:0]      in_h,
    input  logic [DIM_W-1:0]      in_w,
    output logic [DATA_WIDTH-1:0] mul_din0,
    output logic [DATA_WIDTH-1:0] mul_din1,
    input  logic [DATA_WIDTH-1:0] mul_dout,
    max_pooling_fprop1_win_addr_gen_if.master m_axis
);
    state_t                state_q, state_d;
    logic [DIM_W-1:0]      in_h_q, in_h_d, in_w_q, in_w_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d, wl_q, wl_d, tl_q, tl_d;
    logic [DIM_W-1:0]      row, col;
    logic                  cnt_wl, cnt_tl, clear, load, fire;

    max_pooling_fprop1_win_cnt #(.POOL_K(POOL_K), .STRIDE(STRIDE)) u_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (clear),
        .advance  (load),
        .dim_h    (in_h_q),
        .dim_w    (in_w_q),
        .row      (row),
        .col      (col),
        .win_last (cnt_wl),
        .tile_last(cnt_tl)
    );

    // The output register refills when empty or being drained this cycle.
    assign fire     = valid_q & m_axis.addr_ready;
    assign load     = (state_q == RUN) & (~valid_q | m_axis.addr_ready);
    assign clear    = (state_q == IDLE) & ap_start;
    assign mul_din0 = DATA_WIDTH'(row);
    assign mul_din1 = DATA_WIDTH'(in_w_q);
    assign ap_done  = state_q == DONE;
    assign ap_ready = state_q == DONE;
    assign ap_idle  = state_q == IDLE;
    assign m_axis.addr_out   = addr_q;
    assign m_axis.addr_valid = valid_q;
    assign m_axis.win_last   = wl_q;
    assign m_axis.tile_last  = tl_q;

    always_comb begin
        state_d = state_q;
        in_h_d  = in_h_q;
        in_w_d  = in_w_q;
        addr_d  = addr_q;
        valid_d = fire ? 1'b0 : valid_q;
        wl_d    = wl_q;
        tl_d    = tl_q;
        case (state_q)
            IDLE: if (ap_start) begin
                in_h_d  = in_h;
                in_w_d  = in_w;
                state_d = (in_h < DIM_W'(POOL_K) || in_w < DIM_W'(POOL_K)) ? DONE : RUN;
            end
            RUN: if (load) begin
                addr_d  = mul_dout + DATA_WIDTH'(col);
                valid_d = 1'b1;
                wl_d    = cnt_wl;
                tl_d    = cnt_tl;
                state_d = cnt_tl ? DRAIN : RUN;
            end
            DRAIN: state_d = fire ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            in_h_q  <= '0;
            in_w_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            wl_q    <= 1'b0;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            in_h_q  <= in_h_d;
            in_w_q  <= in_w_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            wl_q    <= wl_d;
            tl_q    <= tl_d;
        end
    end
endmodule

// File: tb/tb_max_pooling_fprop1_win_addr_gen.sv
// tb_max_pooling_fprop1_win_addr_gen: checks the address generator against a loop-nest model.
module tb_max_pooling_fprop1_win_addr_gen;
    typedef struct {longint a; bit wl; bit tl;} exp_t;
    typedef exp_t exp_q_t[$];

    logic        ap_clk, ap_rst_n, ap_start, ap_done, ap_idle, ap_ready;
    logic [15:0] in_h, in_w;
    logic [16:0] mul_din0, mul_din1, mul_dout;
    logic        start2, ap_done2, ap_idle2, ap_ready2;
    logic [15:0] in_h2, in_w2;
    logic [16:0] mul2_din0, mul2_din1, mul2_dout;

    int     pass_cnt = 0, tot_cnt = 0, nfired = 0;
    bit     chk_en = 0, use_rnd = 0, deg_done = 0, prev_stall = 0, prev_final = 0;
    logic [16:0] st_a;
    logic        st_wl, st_tl;
    logic [31:0] pat = 32'h9B3C_A5E1;
    exp_q_t q1, q2;

    max_pooling_fprop1_win_addr_gen_if m ();
    max_pooling_fprop1_win_addr_gen_if m2 ();

    max_pooling_fprop1_win_addr_gen dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .in_h(in_h), .in_w(in_w),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout), .m_axis(m)
    );
    max_pooling_fprop1_win_addr_gen #(.STRIDE(8)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start2), .ap_done(ap_done2),
        .ap_idle(ap_idle2), .ap_ready(ap_ready2), .in_h(in_h2), .in_w(in_w2),
        .mul_din0(mul2_din0), .mul_din1(mul2_din1), .mul_dout(mul2_dout), .m_axis(m2)
    );

    // Parent-side 17s x 17s -> 17 multiplier.
    assign mul_dout  = 17'(34'(mul_din0) * 34'(mul_din1));
    assign mul2_dout = 17'(34'(mul2_din0) * 34'(mul2_din1));

    initial ap_clk = 0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s got %0d want %0d", name, act, exp);
    endtask

    function automatic exp_q_t build(input int h, input int w, input int k, input int s);
        exp_q_t q;
        for (int oy = 0; oy + k <= h; oy += s)
            for (int ox = 0; ox + k <= w; ox += s)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++)
                        q.push_back('{a: (longint'(oy + ky) * w + ox + kx) % 131072,
                                      wl: (kx == k - 1 && ky == k - 1), tl: 1'b0});
        if (q.size() > 0) q[q.size()-1].tl = 1'b1;
        return q;
    endfunction

    initial begin
        m.addr_ready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #2;
            pat = {pat[30:0], pat[31]};
            m.addr_ready = use_rnd ? pat[0] : 1'b1;
        end
    end

    always @(negedge ap_clk) begin
        if (chk_en) begin
            exp_t e;
            if (prev_stall)
                chk("stall_hold", {m.addr_valid, m.addr_out, m.win_last, m.tile_last},
                    {1'b1, st_a, st_wl, st_tl});
            chk("ap_done", ap_done, prev_final | deg_done);
            chk("ap_ready", ap_ready, prev_final | deg_done);
            prev_final = 0;
            prev_stall = m.addr_valid & ~m.addr_ready;
            st_a = m.addr_out;
            st_wl = m.win_last;
            st_tl = m.tile_last;
            if (m.addr_valid && m.addr_ready) begin
                if (q1.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL extra_addr got %0d want none", m.addr_out);
                end else begin
                    e = q1.pop_front();
                    chk("addr", m.addr_out, e.a);
                    chk("win_last", m.win_last, e.wl);
                    chk("tile_last", m.tile_last, e.tl);
                    nfired++;
                    prev_final = q1.size() == 0;
                end
            end
        end
    end

    task automatic rst_checks();
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", {ap_done, ap_ready}, 0);
        chk("rst_valid", m.addr_valid, 0);
        chk("rst_outs", {m.addr_out, m.win_last, m.tile_last}, 0);
        chk("rst_mul", {mul_din0, mul_din1}, 0);
    endtask

    task automatic start_job(input int h, input int w, input bit deg);
        @(posedge ap_clk);
        #2;
        in_h = 16'(h);
        in_w = 16'(w);
        ap_start = 1;
        @(posedge ap_clk);
        #2;
        ap_start = 0;
        deg_done = deg;
        @(negedge ap_clk);
        chk("c1_valid", m.addr_valid, 0);
        chk("c1_idle", ap_idle, 0);
        @(posedge ap_clk);
        #2;
        deg_done = 0;
        @(negedge ap_clk);
        if (deg) chk("c2_idle", ap_idle, 1);
        else chk("c2_valid", m.addr_valid, 1);
    endtask

    task automatic run_job(input int h, input int w, input bit rnd);
        bit deg, pd;
        int n;
        deg = h < 2 || w < 2;
        pd = 0;
        n = 0;
        use_rnd = rnd;
        start_job(h, w, deg);
        while (!ap_idle && n < 3000) begin
            pd = ap_done;
            @(negedge ap_clk);
            n++;
        end
        chk("job_end", n < 3000, 1);
        if (!deg) chk("idle_after_done", pd, 1);
        chk("drained", q1.size(), 0);
    endtask

    task automatic reset_abort();
        int n;
        n = 0;
        nfired = 0;
        use_rnd = 0;
        q1 = build(4, 4, 2, 2);
        start_job(4, 4, 0);
        while (nfired < 5 && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("abort_reach5", nfired, 5);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 0;
        #1;
        rst_checks();
        q1.delete();
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1;
    endtask

    task automatic run_wrap();
        int n, last_fire;
        bit seen_done;
        exp_t e;
        n = 0;
        last_fire = -10;
        seen_done = 0;
        q2 = build(10, 16500, 2, 8);
        chk("pin_wrap_size", q2.size(), 16504);
        chk("pin_wrap_addr", q2[8252].a, 928);
        @(posedge ap_clk);
        #2;
        in_h2 = 16'd10;
        in_w2 = 16'd16500;
        start2 = 1;
        @(posedge ap_clk);
        #2;
        start2 = 0;
        while (!seen_done && n < 20000) begin
            @(negedge ap_clk);
            n++;
            seen_done = ap_done2;
            if (m2.addr_valid) begin
                if (q2.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL wrap_extra got %0d want none", m2.addr_out);
                end else begin
                    e = q2.pop_front();
                    last_fire = n;
                    chk("wrap_beat", {m2.addr_out, m2.win_last, m2.tile_last},
                        {e.a[16:0], e.wl, e.tl});
                end
            end
        end
        chk("wrap_done", seen_done, 1);
        chk("wrap_done_lat", n - last_fire, 1);
        chk("wrap_drained", q2.size(), 0);
    endtask

    initial begin
        ap_rst_n = 0;
        ap_start = 0;
        in_h = 0;
        in_w = 0;
        start2 = 0;
        in_h2 = 0;
        in_w2 = 0;
        m2.addr_ready = 1;
        #1;
        rst_checks();
        repeat (2) @(posedge ap_clk);
        #2;
        ap_rst_n = 1;
        chk_en = 1;

        q1 = build(4, 4, 2, 2);
        chk("pin44_a4", q1[4].a, 2);
        chk("pin44_wl3", q1[3].wl, 1);
        chk("pin44_last", {q1[15].a[15:0], q1[15].tl}, {16'd15, 1'b1});
        run_job(4, 4, 0);

        q1 = build(5, 5, 2, 2);
        chk("pin55_a8", q1[8].a, 10);
        chk("pin55_a15", q1[15].a, 18);
        run_job(5, 5, 0);

        q1 = build(4, 4, 2, 2);
        run_job(4, 4, 1);

        q1 = build(1, 4, 2, 2);
        chk("pin_deg", q1.size(), 0);
        run_job(1, 4, 0);

        reset_abort();
        q1 = build(4, 4, 2, 2);
        run_job(4, 4, 0);

        run_wrap();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
